// File: rtl/rf_write_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module   : rf_write_arbiter
// Purpose  : Two-port (ALU / load) register-file writeback arbiter.
//            Each port has its own queue, and the ports take turns round-robin.
// Revision : 1.0
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   input  logic [4:0]  a_dest,
   input  logic [31:0] a_data,
   output logic        a_ready,
   input  logic        b_valid,
   input  logic [4:0]  b_dest,
   input  logic [31:0] b_data,
   output logic        b_ready,
   output logic        rf_wr_en,
   output logic [4:0]  rf_dest,
   output logic [31:0] rf_data,
   output logic [31:0] pending_mask
);

   localparam int c_PW = $clog2(DEPTH);
   localparam int c_CW = c_PW + 1;

   logic [c_PW-1:0] r_wrPtr   [2];
   logic [c_PW-1:0] r_rdPtr   [2];
   logic [c_CW-1:0] r_count   [2];
   logic [4:0]      r_destMem [2][DEPTH];
   logic [31:0]     r_dataMem [2][DEPTH];
   logic            r_preferA;

   logic [1:0]      w_valid;
   logic [1:0]      w_ready;
   logic [1:0]      w_push;
   logic [1:0]      w_nonEmpty;
   logic [1:0]      w_grant;
   logic [4:0]      w_inDest [2];
   logic [31:0]     w_inData [2];
   logic            w_sel;
   logic [4:0]      w_headDest;
   logic [31:0]     w_headData;
   logic [31:0]     w_pending;
   logic [c_PW-1:0] w_offset;

   assign w_valid     = {b_valid, a_valid};
   assign w_inDest[0] = a_dest;
   assign w_inDest[1] = b_dest;
   assign w_inData[0] = a_data;
   assign w_inData[1] = b_data;

   always_comb begin
      w_ready    = '0;
      w_nonEmpty = '0;
      for (int p = 0; p < 2; p++) begin
         w_ready[p]    = (r_count[p] != c_CW'(DEPTH));
         w_nonEmpty[p] = (r_count[p] != '0);
      end
   end

   assign w_push  = w_valid & w_ready;
   assign a_ready = w_ready[0];
   assign b_ready = w_ready[1];

   // The port that did not win last time gets priority when both are waiting.
   assign w_grant[0] = w_nonEmpty[0] && (!w_nonEmpty[1] || r_preferA);
   assign w_grant[1] = w_nonEmpty[1] && !w_grant[0];

   assign w_sel      = w_grant[1];
   assign w_headDest = r_destMem[w_sel][r_rdPtr[w_sel]];
   assign w_headData = r_dataMem[w_sel][r_rdPtr[w_sel]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < 2; p++) begin
            r_wrPtr[p] <= '0;
            r_rdPtr[p] <= '0;
            r_count[p] <= '0;
         end
         r_preferA <= 1'b1;
         rf_wr_en  <= 1'b0;
         rf_dest   <= '0;
         rf_data   <= '0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (w_push[p])
               r_wrPtr[p] <= r_wrPtr[p] + c_PW'(1);
            if (w_grant[p])
               r_rdPtr[p] <= r_rdPtr[p] + c_PW'(1);
            r_count[p] <= r_count[p] + c_CW'(w_push[p]) - c_CW'(w_grant[p]);
         end
         if (w_grant != 2'b00) begin
            r_preferA <= w_grant[1];
            rf_wr_en  <= (w_headDest != 5'd0);
            rf_dest   <= w_headDest;
            rf_data   <= w_headData;
         end else begin
            rf_wr_en  <= 1'b0;
         end
      end
   end

   // Queue storage needs no reset; occupancy alone decides which slots are live.
   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (w_push[p]) begin
            r_destMem[p][r_wrPtr[p]] <= w_inDest[p];
            r_dataMem[p][r_wrPtr[p]] <= w_inData[p];
         end
      end
   end

   always_comb begin
      w_pending = '0;
      w_offset  = '0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < DEPTH; i++) begin
            w_offset = c_PW'(i) - r_rdPtr[p];
            if ({1'b0, w_offset} < r_count[p])
               w_pending[r_destMem[p][i]] = 1'b1;
         end
      end
   end

   assign pending_mask = w_pending;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module   : tb_rf_write_arbiter
// Purpose  : Directed bench for rf_write_arbiter with a queue-level reference model.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_rf_write_arbiter;

   localparam int DEPTH = 2;

   typedef struct {
      logic [4:0]  d;
      logic [31:0] v;
   } ent_t;

   logic        clk;
   logic        rst;
   logic        a_valid, b_valid;
   logic [4:0]  a_dest, b_dest;
   logic [31:0] a_data, b_data;
   logic        a_ready, b_ready;
   logic        rf_wr_en;
   logic [4:0]  rf_dest;
   logic [31:0] rf_data;
   logic [31:0] pending_mask;

   int   total = 0;
   int   bad   = 0;
   bit   checkEn = 0;

   ent_t mA[$], mB[$];
   ent_t sA[$], sB[$];
   bit          mPreferA;
   logic        expWr;
   logic [4:0]  expDest;
   logic [31:0] expData;

   rf_write_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data), .b_ready(b_ready),
      .rf_wr_en(rf_wr_en), .rf_dest(rf_dest), .rf_data(rf_data),
      .pending_mask(pending_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", n, act, exp);
      end
   endtask

   function automatic logic [31:0] model_mask();
      logic [31:0] m;
      m = '0;
      foreach (mA[i]) m[mA[i].d] = 1'b1;
      foreach (mB[i]) m[mB[i].d] = 1'b1;
      return m;
   endfunction

   function automatic void model_reset();
      mA.delete();
      mB.delete();
      mPreferA = 1'b1;
      expWr    = 1'b0;
      expDest  = '0;
      expData  = '0;
   endfunction

   // One rising edge: grant from the queues as they stood, then accept new entries.
   function automatic void model_step();
      ent_t e;
      bit   accA, accB, gA, gB;
      accA = a_valid && (mA.size() < DEPTH);
      accB = b_valid && (mB.size() < DEPTH);
      gA   = (mA.size() > 0) && ((mB.size() == 0) || mPreferA);
      gB   = !gA && (mB.size() > 0);
      if (gA) begin
         e = mA.pop_front();
         expWr = (e.d != 0); expDest = e.d; expData = e.v; mPreferA = 1'b0;
      end else if (gB) begin
         e = mB.pop_front();
         expWr = (e.d != 0); expDest = e.d; expData = e.v; mPreferA = 1'b1;
      end else begin
         expWr = 1'b0;
      end
      if (accA) mA.push_back('{a_dest, a_data});
      if (accB) mB.push_back('{b_dest, b_data});
   endfunction

   task automatic drive();
      a_valid = (sA.size() > 0);
      b_valid = (sB.size() > 0);
      a_dest  = (sA.size() > 0) ? sA[0].d : 5'd0;
      a_data  = (sA.size() > 0) ? sA[0].v : 32'd0;
      b_dest  = (sB.size() > 0) ? sB[0].d : 5'd0;
      b_data  = (sB.size() > 0) ? sB[0].v : 32'd0;
   endtask

   task automatic tick();
      bit accA, accB;
      accA = a_valid && a_ready;
      accB = b_valid && b_ready;
      @(posedge clk);
      if (!rst) model_step();
      #1;
      if (accA) void'(sA.pop_front());
      if (accB) void'(sB.pop_front());
      drive();
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      model_reset();
      sA.delete();
      sB.delete();
      drive();
      #1;
      check("rst_mask", pending_mask, 32'h0);
      check("rst_wr_en", rf_wr_en, 1'b0);
      @(negedge clk);
      #1 rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (checkEn) begin
         check("cyc_wr_en", rf_wr_en, expWr);
         check("cyc_dest", rf_dest, expDest);
         check("cyc_data", rf_data, expData);
         check("cyc_mask", pending_mask, model_mask());
         check("cyc_a_ready", a_ready, mA.size() < DEPTH);
         check("cyc_b_ready", b_ready, mB.size() < DEPTH);
      end
   end

   initial begin
      rst = 1'b1;
      model_reset();
      drive();
      checkEn = 1'b1;
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;

      check("reset_wr_en", rf_wr_en, 1'b0);
      check("reset_dest", rf_dest, 5'd0);
      check("reset_data", rf_data, 32'h0);
      check("reset_mask", pending_mask, 32'h0);
      check("reset_a_ready", a_ready, 1'b1);
      check("reset_b_ready", b_ready, 1'b1);

      // Single write from A
      sA.push_back('{5'd5, 32'h1234});
      drive();
      tick();
      check("single_mask", pending_mask, 32'h0000_0020);
      tick();
      check("single_wr_en", rf_wr_en, 1'b1);
      check("single_dest", rf_dest, 5'd5);
      check("single_data", rf_data, 32'h1234);
      check("single_mask_clr", pending_mask, 32'h0);
      tick();
      check("single_wr_off", rf_wr_en, 1'b0);
      check("single_dest_hold", rf_dest, 5'd5);

      // Contention: expect 1,3,2,4
      reset_pulse();
      sA.push_back('{5'd1, 32'hA1}); sA.push_back('{5'd2, 32'hA2});
      sB.push_back('{5'd3, 32'hB3}); sB.push_back('{5'd4, 32'hB4});
      drive();
      tick();
      tick(); check("cont_dest0", rf_dest, 5'd1); check("cont_wr0", rf_wr_en, 1'b1);
      tick(); check("cont_dest1", rf_dest, 5'd3);
      tick(); check("cont_dest2", rf_dest, 5'd2);
      tick(); check("cont_dest3", rf_dest, 5'd4); check("cont_data3", rf_data, 32'hB4);
      tick(); check("cont_idle", rf_wr_en, 1'b0);

      // Full queue on A while B steals grants
      reset_pulse();
      for (int i = 11; i <= 14; i++) sA.push_back('{5'(i), 32'(i * 16)});
      sB.push_back('{5'd21, 32'h21}); sB.push_back('{5'd22, 32'h22});
      drive();
      repeat (3) tick();
      check("full_a_ready", a_ready, 1'b0);
      check("full_mask", pending_mask, 32'h0040_3000);
      tick();
      check("full_a_ready_back", a_ready, 1'b1);
      check("full_dest", rf_dest, 5'd12);
      repeat (6) tick();

      // Write to $zero
      reset_pulse();
      sB.push_back('{5'd0, 32'hFFFF});
      drive();
      tick();
      check("zero_mask", pending_mask, 32'h0000_0001);
      tick();
      check("zero_wr_en", rf_wr_en, 1'b0);
      check("zero_data", rf_data, 32'hFFFF);
      check("zero_mask_clr", pending_mask, 32'h0);

      // Pending mask
      reset_pulse();
      sA.push_back('{5'd7, 32'h77}); sB.push_back('{5'd9, 32'h99});
      drive();
      tick(); check("pend_both", pending_mask, 32'h0000_0280);
      tick(); check("pend_b", pending_mask, 32'h0000_0200);
      tick(); check("pend_none", pending_mask, 32'h0);

      // Reset in the middle of traffic
      reset_pulse();
      sA.push_back('{5'd3, 32'h3}); sA.push_back('{5'd4, 32'h4});
      sB.push_back('{5'd5, 32'h5}); sB.push_back('{5'd6, 32'h6});
      drive();
      tick();
      tick();
      reset_pulse();
      for (int i = 0; i < 5; i++) begin
         tick();
         check("midrst_wr_en", rf_wr_en, 1'b0);
      end

      @(negedge clk);
      #1 checkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
